// File: rtl/pipelineGlobals.sv
// Constants and state encoding shared by the bot-feed scheduler and its pipeline.
package pipelineGlobals;

  localparam int unsigned ADDR_WIDTH          = 14;
  localparam int unsigned OUTPUT_INDEX_OFFSET = (32'd1 << ADDR_WIDTH) - 32'd4;
  localparam int unsigned OUTPUT_READ_LATENCY = 2;
  localparam int unsigned OUTPUT_LAG          = (32'd1 << ADDR_WIDTH) - OUTPUT_INDEX_OFFSET
                                                + OUTPUT_READ_LATENCY;
  localparam int unsigned PIPE_LAG            = OUTPUT_LAG;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } schedState_e;

  // Bot-memory addresses wrap silently at the top of the address space.
  function automatic logic [ADDR_WIDTH-1:0] wrapAddr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [ADDR_WIDTH-1:0] offset
  );
    return base + offset;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Shift register of bot-valid strobes with one intermediate tap and the final tap.
module valid_delay_line #(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned TAP    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tap,
  output logic last
);

  logic [LENGTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[LENGTH-2:0], din};
    end
  end

  // stages[k] holds the strobe from k+1 cycles ago.
  assign tap  = stages[TAP-1];
  assign last = stages[LENGTH-1];

endmodule

// File: rtl/bot_feed_scheduler.sv
// Job-level controller: issues a contiguous range of bot reads into the pipeline under
// fullness back-pressure and sums the per-bot results into one report per job.
module bot_feed_scheduler
  import pipelineGlobals::*;
#(
  parameter int unsigned FULLNESS_LIMIT = 30,
  parameter int unsigned MEM_LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jobValid,
  output logic                  jobReady,
  input  logic [127:0]          jobTop,
  input  logic [ADDR_WIDTH-1:0] jobBase,
  input  logic [ADDR_WIDTH:0]   jobCount,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRead,
  output logic [127:0]          top,
  output logic                  isBotValid,
  input  logic [4:0]            maxFullness,
  input  logic [39:0]           summedData,
  input  logic [4:0]            pcoeffCount,
  output logic                  resultValid,
  output logic [63:0]           resultSum,
  output logic [ADDR_WIDTH+5:0] resultCount,
  output logic                  busy
);

  localparam int unsigned LINE_LEN     = MEM_LATENCY + PIPE_LAG;
  localparam int unsigned COUNT_WIDTH  = ADDR_WIDTH + 1;
  localparam int unsigned RES_CNT_W    = ADDR_WIDTH + 6;
  localparam int unsigned FLIGHT_WIDTH = $clog2(LINE_LEN + 1) + 1;

  schedState_e             state;
  logic [ADDR_WIDTH-1:0]   base;
  logic [COUNT_WIDTH-1:0]  count;
  logic [COUNT_WIDTH-1:0]  issued;
  logic [FLIGHT_WIDTH-1:0] inFlight;

  logic                    fullnessOk;
  logic                    accept;
  logic                    issue;
  logic                    lastIssue;
  logic                    resHit;
  logic                    drainDone;
  logic [ADDR_WIDTH-1:0]   issueAddr;

  valid_delay_line #(
    .LENGTH (LINE_LEN),
    .TAP    (MEM_LATENCY)
  ) u_validLine (
    .clk  (clk),
    .rst  (rst),
    .din  (memRead),
    .tap  (isBotValid),
    .last (resHit)
  );

  // Issue decision: the first read may go out on the acceptance edge itself.
  always_comb begin
    fullnessOk = 32'(maxFullness) < FULLNESS_LIMIT;
    accept     = (state == IDLE) && jobValid && jobReady;
    issue      = 1'b0;
    lastIssue  = 1'b0;
    issueAddr  = wrapAddr(base, issued[ADDR_WIDTH-1:0]);
    if (accept) begin
      issue     = (jobCount != '0) && fullnessOk;
      lastIssue = jobCount == COUNT_WIDTH'(1);
      issueAddr = jobBase;
    end else if (state == ISSUE) begin
      issue     = fullnessOk;
      lastIssue = (issued + COUNT_WIDTH'(1)) == count;
    end
    drainDone = inFlight == FLIGHT_WIDTH'(resHit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      jobReady    <= 1'b0;
      busy        <= 1'b0;
      memRead     <= 1'b0;
      memAddr     <= '0;
      top         <= '0;
      base        <= '0;
      count       <= '0;
      issued      <= '0;
      inFlight    <= '0;
      resultValid <= 1'b0;
      resultSum   <= '0;
      resultCount <= '0;
    end else begin
      memRead     <= issue;
      resultValid <= 1'b0;
      inFlight    <= inFlight + FLIGHT_WIDTH'(memRead) - FLIGHT_WIDTH'(resHit);
      if (issue) begin
        memAddr <= issueAddr;
      end
      if (resHit) begin
        resultSum   <= resultSum + 64'(summedData);
        resultCount <= resultCount + RES_CNT_W'(pcoeffCount);
      end

      case (state)
        IDLE: begin
          if (accept) begin
            top         <= jobTop;
            base        <= jobBase;
            count       <= jobCount;
            issued      <= COUNT_WIDTH'(issue);
            resultSum   <= '0;
            resultCount <= '0;
            jobReady    <= 1'b0;
            busy        <= 1'b1;
            // An empty job, or a single bot issued at acceptance, has nothing left to issue.
            if ((jobCount == '0) || (issue && lastIssue)) begin
              state <= DRAIN;
            end else begin
              state <= ISSUE;
            end
          end else begin
            jobReady <= 1'b1;
            busy     <= 1'b0;
          end
        end
        ISSUE: begin
          if (issue) begin
            issued <= issued + COUNT_WIDTH'(1);
            if (lastIssue) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final read may still be on memRead and not yet counted in inFlight.
          if (!memRead && drainDone) begin
            state       <= REPORT;
            resultValid <= 1'b1;
          end
        end
        REPORT: begin
          state    <= IDLE;
          jobReady <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bot_feed_scheduler.sv
// Self-checking bench: a job-level timeline model predicts every output each cycle.
module tb_bot_feed_scheduler;
  import pipelineGlobals::*;

  localparam int MEM_LAT = 2;
  localparam int LIMIT   = 30;
  localparam int LINE    = MEM_LAT + int'(OUTPUT_LAG);
  localparam int MAXC    = 20000;

  logic         clk = 1'b0;
  logic         rst;
  logic         jobValid;
  logic         jobReady;
  logic [127:0] jobTop;
  logic [13:0]  jobBase;
  logic [14:0]  jobCount;
  logic [13:0]  memAddr;
  logic         memRead;
  logic [127:0] top;
  logic         isBotValid;
  logic [4:0]   maxFullness;
  logic [39:0]  summedData;
  logic [4:0]   pcoeffCount;
  logic         resultValid;
  logic [63:0]  resultSum;
  logic [19:0]  resultCount;
  logic         busy;

  bot_feed_scheduler #(.FULLNESS_LIMIT(LIMIT), .MEM_LATENCY(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .jobValid(jobValid), .jobReady(jobReady), .jobTop(jobTop),
    .jobBase(jobBase), .jobCount(jobCount), .memAddr(memAddr), .memRead(memRead),
    .top(top), .isBotValid(isBotValid), .maxFullness(maxFullness),
    .summedData(summedData), .pcoeffCount(pcoeffCount), .resultValid(resultValid),
    .resultSum(resultSum), .resultCount(resultCount), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit checkEn = 0;

  // Model: which cycles carry an expected read, and the job timeline.
  bit          rdBit [MAXC];
  logic [13:0] rdAddr[MAXC];
  int          histFloor = 0;
  bit          mActive = 0;
  int          remaining = 0;
  logic [13:0] nextAddr = '0;
  int          rvCycle = -1;

  bit           eMemRead, eIsBotValid, eResultValid, eBusy, eJobReady;
  logic [13:0]  eMemAddr;
  logic [127:0] eTop;
  logic [63:0]  eSum;
  logic [19:0]  eCnt;

  logic [39:0] forcedSum[$];
  logic [4:0]  forcedCnt[$];

  // Observed DUT events for the hand-computed checks.
  int          acceptCycle, firstRead, lastRead, readCnt, firstBv, rvSeen, rvPulses;
  logic [13:0] addrLog[$];
  logic [63:0] rvSum;
  logic [19:0] rvCnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit readAt(input int k);
    if (k < histFloor || k < 0 || k >= MAXC) return 1'b0;
    return rdBit[k];
  endfunction

  task automatic clearLog();
    firstRead = -1; lastRead = -1; readCnt = 0; firstBv = -1;
    rvSeen = -1; rvPulses = 0; addrLog.delete();
    rvSum = '0; rvCnt = '0;
  endtask

  task automatic compareAll();
    check("jobReady", 128'(jobReady), 128'(eJobReady));
    check("busy", 128'(busy), 128'(eBusy));
    check("memRead", 128'(memRead), 128'(eMemRead));
    check("memAddr", 128'(memAddr), 128'(eMemAddr));
    check("isBotValid", 128'(isBotValid), 128'(eIsBotValid));
    check("resultValid", 128'(resultValid), 128'(eResultValid));
    check("top", top, eTop);
    if (eResultValid || !eBusy) begin
      check("resultSum", 128'(resultSum), 128'(eSum));
      check("resultCount", 128'(resultCount), 128'(eCnt));
    end
    if (memRead === 1'b1) begin
      if (readCnt == 0) firstRead = cyc;
      lastRead = cyc;
      readCnt++;
      addrLog.push_back(memAddr);
    end
    if (isBotValid === 1'b1 && firstBv < 0) firstBv = cyc;
    if (resultValid === 1'b1) begin
      rvPulses++; rvSeen = cyc; rvSum = resultSum; rvCnt = resultCount;
    end
  endtask

  // Predict outputs of cycle cyc+1 from the inputs driven in cycle cyc.
  task automatic modelStep();
    int n;
    n = cyc + 1;
    rdBit[n] = 1'b0;
    if (rst) begin
      mActive = 0; remaining = 0; rvCycle = -1; histFloor = n;
      eTop = '0; eSum = '0; eCnt = '0; eBusy = 0; eJobReady = 0;
      eResultValid = 0; eMemRead = 0; eMemAddr = '0; eIsBotValid = 0;
    end else begin
      if (mActive && rvCycle == cyc) begin
        mActive = 0; rvCycle = -1;
      end
      if (!mActive && jobValid && eJobReady) begin
        mActive = 1; eTop = jobTop; eSum = '0; eCnt = '0;
        remaining = int'(jobCount); nextAddr = jobBase;
        if (remaining == 0) rvCycle = cyc + 2;
      end
      if (mActive && remaining > 0 && int'(maxFullness) < LIMIT) begin
        rdBit[n] = 1'b1; rdAddr[n] = nextAddr;
        nextAddr = nextAddr + 14'd1;
        remaining--;
        if (remaining == 0) rvCycle = n + LINE + 1;
      end
      eResultValid = (rvCycle == n);
      eBusy        = mActive;
      eJobReady    = !mActive;
      eMemRead     = rdBit[n];
      if (eMemRead) eMemAddr = rdAddr[n];
      eIsBotValid  = readAt(n - MEM_LAT);
    end
  endtask

  // Pipeline stand-in: a result appears exactly when a read's lag expires.
  task automatic driveResults();
    logic [39:0] v;
    logic [4:0]  p;
    if (readAt(cyc - LINE)) begin
      if (forcedSum.size() > 0) begin
        v = forcedSum.pop_front(); p = forcedCnt.pop_front();
      end else begin
        v = 40'({$urandom(), $urandom()}); p = 5'($urandom());
      end
      eSum = eSum + 64'(v);
      eCnt = eCnt + 20'(p);
    end else begin
      v = 40'({$urandom(), $urandom()}); p = 5'($urandom());
    end
    summedData = v;
    pcoeffCount = p;
  endtask

  task automatic tick();
    @(negedge clk);
    if (checkEn) compareAll();
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC - LINE - 4) begin
      $display("FAIL cycle_budget: reached %0d cycles, limit %0d", cyc, MAXC - LINE - 4);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "cycle budget exhausted");
    end
    driveResults();
  endtask

  task automatic runJob(input logic [13:0] b, input logic [14:0] n, input logic [127:0] t);
    bit accepted;
    int guard;
    jobValid = 1'b1; jobBase = b; jobCount = n; jobTop = t;
    accepted = 0; guard = 0;
    while (!accepted) begin
      if (guard > 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: job not taken after %0d cycles, required within 50", guard);
        break;
      end
      if (!mActive && eJobReady && !rst && jobValid) begin
        accepted = 1; acceptCycle = cyc;
      end
      tick();
      guard++;
    end
    jobValid = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (mActive) begin
      if (guard > 3000) begin
        checks++; errors++;
        $display("FAIL done_timeout: job still active after %0d cycles, required within 3000", guard);
        break;
      end
      tick();
      guard++;
    end
  endtask

  initial begin
    rst = 1'b1; jobValid = 1'b0; jobTop = '0; jobBase = '0; jobCount = '0;
    maxFullness = '0; summedData = '0; pcoeffCount = '0;
    clearLog();
    tick();
    checkEn = 1;
    tick(); tick();
    check("rst_jobReady", 128'(jobReady), 128'(0));
    check("rst_resultSum", 128'(resultSum), 128'(0));
    rst = 1'b0;
    tick(); tick();
    check("post_rst_jobReady", 128'(jobReady), 128'(1));

    // One bot at 0x0005 returning (7,3).
    clearLog(); forcedSum.push_back(40'd7); forcedCnt.push_back(5'd3);
    runJob(14'h0005, 15'd1, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    waitIdle();
    check("t1_firstRead", 128'(firstRead - acceptCycle), 128'(1));
    check("t1_addr", 128'(addrLog.size() > 0 ? addrLog[0] : 14'h3FFF), 128'(14'h0005));
    check("t1_botValid", 128'(firstBv - acceptCycle), 128'(3));
    check("t1_rvCycle", 128'(rvSeen - acceptCycle), 128'(1 + MEM_LAT + int'(OUTPUT_LAG) + 1));
    check("t1_sum", 128'(rvSum), 128'(7));
    check("t1_count", 128'(rvCnt), 128'(3));
    check("t1_pulses", 128'(rvPulses), 128'(1));

    // Four bots under a 10-cycle fullness hold.
    clearLog(); maxFullness = 5'd30;
    runJob(14'h0100, 15'd4, 128'h1);
    for (int i = 0; i < 9; i++) tick();
    maxFullness = 5'd0;
    waitIdle();
    check("t2_firstRead", 128'(firstRead - acceptCycle), 128'(11));
    check("t2_lastRead", 128'(lastRead - acceptCycle), 128'(14));
    check("t2_reads", 128'(readCnt), 128'(4));
    for (int i = 0; i < 4 && i < addrLog.size(); i++)
      check("t2_addr", 128'(addrLog[i]), 128'(14'h0100 + 14'(i)));

    // Address wrap.
    clearLog();
    runJob(14'h3FFE, 15'd4, 128'h2);
    waitIdle();
    check("t3_reads", 128'(readCnt), 128'(4));
    if (addrLog.size() == 4) begin
      check("t3_addr0", 128'(addrLog[0]), 128'(14'h3FFE));
      check("t3_addr1", 128'(addrLog[1]), 128'(14'h3FFF));
      check("t3_addr2", 128'(addrLog[2]), 128'(14'h0000));
      check("t3_addr3", 128'(addrLog[3]), 128'(14'h0001));
    end

    // Three bots with known results.
    clearLog();
    forcedSum.push_back(40'd10); forcedCnt.push_back(5'd1);
    forcedSum.push_back(40'd20); forcedCnt.push_back(5'd2);
    forcedSum.push_back(40'd30); forcedCnt.push_back(5'd3);
    runJob(14'h0200, 15'd3, 128'h3);
    waitIdle();
    check("t4_sum", 128'(rvSum), 128'(60));
    check("t4_count", 128'(rvCnt), 128'(6));
    check("t4_rvCycle", 128'(rvSeen - acceptCycle), 128'(3 + MEM_LAT + int'(OUTPUT_LAG) + 1));
    check("t4_pulses", 128'(rvPulses), 128'(1));

    // Empty job.
    clearLog();
    runJob(14'h0300, 15'd0, 128'h4);
    waitIdle();
    check("t5_rvCycle", 128'(rvSeen - acceptCycle), 128'(2));
    check("t5_reads", 128'(readCnt), 128'(0));
    check("t5_sum", 128'(rvSum), 128'(0));
    check("t5_count", 128'(rvCnt), 128'(0));
    check("t5_pulses", 128'(rvPulses), 128'(1));

    // Reset after three of eight reads.
    clearLog();
    runJob(14'h0400, 15'd8, 128'h5);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_reads", 128'(readCnt), 128'(3));
    check("t6_memRead", 128'(memRead), 128'(0));
    check("t6_botValid", 128'(isBotValid), 128'(0));
    check("t6_busy", 128'(busy), 128'(0));
    for (int i = 0; i < 15; i++) tick();
    check("t6_noResult", 128'(rvPulses), 128'(0));
    clearLog();
    forcedSum.push_back(40'd5); forcedCnt.push_back(5'd1);
    forcedSum.push_back(40'd6); forcedCnt.push_back(5'd2);
    runJob(14'h0500, 15'd2, 128'h6);
    waitIdle();
    check("t6_sum", 128'(rvSum), 128'(11));
    check("t6_count", 128'(rvCnt), 128'(3));

    // Randomized jobs with back-pressure and occasional mid-job reset.
    for (int j = 0; j < 40; j++) begin
      int gap;
      int rstAt;
      bit doRst;
      int guard;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        maxFullness = 5'($urandom_range(0, 31));
        tick();
      end
      maxFullness = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(30, 31))
                                                : 5'($urandom_range(0, 29));
      runJob(14'($urandom()), ($urandom_range(0, 7) == 0) ? 15'd0 : 15'($urandom_range(1, 12)),
             {$urandom(), $urandom(), $urandom(), $urandom()});
      doRst = ($urandom_range(0, 9) == 0);
      rstAt = acceptCycle + $urandom_range(1, 12);
      guard = 0;
      while (mActive && guard < 3000) begin
        maxFullness = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(30, 31))
                                                  : 5'($urandom_range(0, 29));
        rst = doRst && (cyc == rstAt);
        tick();
        guard++;
      end
      rst = 1'b0;
      if (guard >= 3000) begin
        checks++; errors++;
        $display("FAIL random_timeout: job %0d still active after %0d cycles, required under 3000", j, guard);
      end
    end
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
